// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_pkg
//  Description : Shared types and constants for the typematic key FIFO.
//                Repeat FSM state encoding, default typematic timings, the
//                "no key" code, and a small helper for sizing the timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package key_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_HELD   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    localparam int KEY_DELAY_CYC_DEF = 300000;
    localparam int KEY_RATE_CYC_DEF  = 30000;
    localparam int KEY_NONE          = 0;

    function automatic int key_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : key_pkg
`default_nettype wire

// File: rtl/key_repeat.sv
`default_nettype none
// ============================================================================
//  Module      : key_repeat
//  Description : Typematic repeat engine. Turns a level key-code stream
//                (0 = no key) into single-cycle push requests: one on press
//                or code change, one after DELAY_CYC held cycles, then one
//                every RATE_CYC cycles while the same code stays held.
//  Ports       : clk         - system clock, rising edge
//                rstn        - synchronous active-low reset
//                key_code_i  - current decoded key, 0 = none
//                push_o      - push request, valid in the current cycle
//                push_data_o - code to push when push_o is high
//  Revision    : 1.0 - initial release
// ============================================================================
module key_repeat
    import key_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DELAY_CYC = KEY_DELAY_CYC_DEF,
    parameter int RATE_CYC  = KEY_RATE_CYC_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] key_code_i,
    output logic              push_o,
    output logic [DATA_W-1:0] push_data_o
);

    // Floor of 2 keeps the timer at least one bit wide for degenerate timings.
    localparam int TMR_W = $clog2(key_max(key_max(DELAY_CYC, RATE_CYC), 2));
    localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(DELAY_CYC - 1);
    localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(RATE_CYC - 1);
    localparam logic [DATA_W-1:0] NONE      = DATA_W'(KEY_NONE);

    rpt_state_t        state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DATA_W-1:0] prev_q,  prev_d;

    // Push decisions are combinational so a new key is written into the
    // FIFO on the same edge that first samples it.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        prev_d      = prev_q;
        push_o      = 1'b0;
        push_data_o = key_code_i;
        case (state_q)
            RPT_IDLE: begin
                if (key_code_i != NONE) begin
                    push_o  = 1'b1;
                    prev_d  = key_code_i;
                    timer_d = '0;
                    state_d = RPT_HELD;
                end
            end
            RPT_HELD: begin
                if (key_code_i == NONE) begin
                    state_d = RPT_IDLE;
                end else if (key_code_i != prev_q) begin
                    push_o  = 1'b1;
                    prev_d  = key_code_i;
                    timer_d = '0;
                end else if (timer_q == DELAY_LAST) begin
                    push_o      = 1'b1;
                    push_data_o = prev_q;
                    timer_d     = '0;
                    state_d     = RPT_REPEAT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RPT_REPEAT: begin
                if (key_code_i == NONE) begin
                    state_d = RPT_IDLE;
                end else if (key_code_i != prev_q) begin
                    push_o  = 1'b1;
                    prev_d  = key_code_i;
                    timer_d = '0;
                    state_d = RPT_HELD;
                end else if (timer_q == RATE_LAST) begin
                    push_o      = 1'b1;
                    push_data_o = prev_q;
                    timer_d     = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = RPT_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= RPT_IDLE;
            timer_q <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            prev_q  <= prev_d;
        end
    end

endmodule : key_repeat
`default_nettype wire

// File: rtl/key_fifo_rpt.sv
`default_nettype none
// ============================================================================
//  Module      : key_fifo_rpt
//  Description : Keyboard event queue with typematic auto-repeat. Key press
//                and repeat events from key_repeat are buffered in a
//                power-of-two circular FIFO popped by the CPU via rd_en.
//  Ports       : clk      - system clock, rising edge
//                rstn     - synchronous active-low reset
//                key_code - current decoded key, 0 = none
//                rd_en    - pop strobe, one entry per asserted cycle
//                rd_data  - head entry, 0 when empty
//                empty    - no entries held
//                full     - DEPTH entries held
//                count    - current occupancy
//                overflow - sticky, set when a push is dropped
//                flush    - clears the queue (only with KEY_FIFO_FLUSH_EN)
//  Config      : define KEY_FIFO_FLUSH_EN to add the flush input.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_fifo_rpt
    import key_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 64,
    parameter int DELAY_CYC = KEY_DELAY_CYC_DEF,
    parameter int RATE_CYC  = KEY_RATE_CYC_DEF
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [DATA_W-1:0]        key_code,
    input  logic                     rd_en,
`ifdef KEY_FIFO_FLUSH_EN
    input  logic                     flush,
`endif
    output logic [DATA_W-1:0]        rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              push;
    logic [DATA_W-1:0] push_data;

    key_repeat #(
        .DATA_W    (DATA_W),
        .DELAY_CYC (DELAY_CYC),
        .RATE_CYC  (RATE_CYC)
    ) u_key_repeat (
        .clk         (clk),
        .rstn        (rstn),
        .key_code_i  (key_code),
        .push_o      (push),
        .push_data_o (push_data)
    );

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              do_pop;
    logic              do_push;
    logic              flush_act;

`ifdef KEY_FIFO_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    // A pop frees the slot the simultaneous push needs, so a full FIFO
    // accepts a push in the same cycle as a pop. Pops on empty are ignored.
    assign do_pop  = rd_en & ~empty & ~flush_act;
    assign do_push = push & (~full | do_pop) & ~flush_act;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush_act) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (do_pop) begin
                head_d = head_q + 1'b1;
            end
            if (do_push) begin
                tail_d = tail_q + 1'b1;
            end
            if (push && !do_push) begin
                overflow_d = 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left uncleared by reset; empty masks rd_data.
    always_ff @(posedge clk) begin
        if (rstn && do_push) begin
            mem_q[tail_q] <= push_data;
        end
    end

    assign rd_data  = empty ? '0 : mem_q[head_q];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule : key_fifo_rpt
`default_nettype wire

// File: tb/tb_key_fifo_rpt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_fifo_rpt
//  Description : Directed self-checking bench for key_fifo_rpt with
//                DEPTH=4, DELAY_CYC=10, RATE_CYC=3.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_fifo_rpt;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rstn;
    logic [DATA_W-1:0] key_code;
    logic              rd_en;
    logic              flush;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic [2:0]        count;
    logic              overflow;

    int checks;
    int errors;

    key_fifo_rpt #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .DELAY_CYC (10),
        .RATE_CYC  (3)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .key_code (key_code),
        .rd_en    (rd_en),
`ifdef KEY_FIFO_FLUSH_EN
        .flush    (flush),
`endif
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle before sampling / driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        key_code = '0;
        rd_en = 1'b0;
        flush = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        chk(tag, rd_data, exp);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        do_reset();

        // 1: idle after reset
        for (int i = 0; i < 5; i++) step();
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_rdata", rd_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_full", full, 0);

        // 2: single tap
        key_code = 8'h41;
        step();
        chk("tap_count", count, 1);
        chk("tap_rdata", rd_data, 8'h41);
        key_code = 8'h00;
        step();
        chk("tap_norpt", count, 1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("tap_pop_empty", empty, 1);
        chk("tap_pop_rdata", rd_data, 0);

        // 3: hold 20 cycles, pushes at 0,10,13,16; 19 dropped
        key_code = 8'h41;
        for (int i = 0; i < 20; i++) begin
            int exp_cnt;
            step();
            exp_cnt = (i >= 16) ? 4 : (i >= 13) ? 3 : (i >= 10) ? 2 : 1;
            chk("hold_count", count, exp_cnt);
            if (i == 16) begin
                chk("hold_full", full, 1);
                chk("hold_ovf_pre", overflow, 0);
            end
        end
        chk("hold_ovf", overflow, 1);
        key_code = 8'h00;
        step();
        chk("hold_rdata", rd_data, 8'h41);
        do_reset();
        chk("rst2_ovf", overflow, 0);
        chk("rst2_count", count, 0);

        // 4: code change, no repeat
        key_code = 8'h41;
        step(); step(); step();
        key_code = 8'h42;
        step();
        key_code = 8'h00;
        for (int i = 0; i < 15; i++) step();
        chk("chg_count", count, 2);
        pop_expect("chg_e0", 8'h41);
        pop_expect("chg_e1", 8'h42);
        chk("chg_empty", empty, 1);

        // empty FIFO: push with rd_en same cycle
        key_code = 8'h55;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        key_code = 8'h00;
        chk("emp_pp_count", count, 1);
        chk("emp_pp_rdata", rd_data, 8'h55);
        do_reset();

        // 5: full, pop coincides with repeat push
        key_code = 8'h41; step();
        key_code = 8'h42; step();
        key_code = 8'h43; step();
        key_code = 8'h44; step();          // edge 3: fourth push
        chk("fp_full", full, 1);
        for (int i = 0; i < 9; i++) step(); // edges 4..12
        chk("fp_count_pre", count, 4);
        chk("fp_ovf_pre", overflow, 0);
        rd_en = 1'b1;
        step();                             // edge 13: repeat push + pop
        rd_en = 1'b0;
        key_code = 8'h00;
        chk("fp_count", count, 4);
        chk("fp_ovf", overflow, 0);
        pop_expect("fp_e0", 8'h42);
        pop_expect("fp_e1", 8'h43);
        pop_expect("fp_e2", 8'h44);
        pop_expect("fp_e3", 8'h44);
        chk("fp_empty", empty, 1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("underflow_count", count, 0);

`ifdef KEY_FIFO_FLUSH_EN
        // 6: flush with rd_en
        do_reset();
        key_code = 8'h41; step();
        key_code = 8'h42; step();
        key_code = 8'h43; step();
        key_code = 8'h00; step();
        chk("fl_count_pre", count, 3);
        flush = 1'b1;
        rd_en = 1'b1;
        step();
        flush = 1'b0;
        rd_en = 1'b0;
        chk("fl_count", count, 0);
        chk("fl_empty", empty, 1);
        chk("fl_ovf", overflow, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_key_fifo_rpt
`default_nettype wire
